// File: rtl/score_disp_pkg.sv
// Shared constants for the score display: segment codes, converter state encoding,
// and helpers for decimal limits and segment decode.
package score_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110010;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/score_display_mux_bin2bcd_seq.sv
// Sequential double-dabble converter: samples the score when it changes, clamps it
// to the display range, and publishes BCD digits plus an overflow flag.
module bin2bcd_seq
  import score_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SCORE_W-1:0]      score,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    busy,
  output logic                    ovf
);

  localparam int         BCD_W   = 4 * NUM_DIGITS;
  localparam int         CNT_W   = $clog2(SCORE_W + 1);
  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  logic [1:0]         state;
  logic [SCORE_W-1:0] last_score;
  logic [SCORE_W-1:0] bin_sh;
  logic [BCD_W-1:0]   bcd_work;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   bit_cnt;
  logic               ovf_pend;
  logic               over_max;

  assign over_max = (64'(score) > MAX_VAL);

  // Pre-shift correction: any nibble of 5 or more gets +3 so the shift carries into the next decade.
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_work[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_score <= '0;
      bin_sh     <= '0;
      bcd_work   <= '0;
      bit_cnt    <= '0;
      ovf_pend   <= 1'b0;
      bcd        <= '0;
      busy       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (score != last_score) begin
            last_score <= score;
            if (over_max) begin
              bin_sh   <= MAX_VAL[SCORE_W-1:0];
              ovf_pend <= 1'b1;
            end else begin
              bin_sh   <= score;
              ovf_pend <= 1'b0;
            end
            bit_cnt  <= CNT_W'(SCORE_W);
            bcd_work <= '0;
            busy     <= 1'b1;
            state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          {bcd_work, bin_sh} <= {bcd_adj, bin_sh} << 1;
          bit_cnt            <= bit_cnt - CNT_W'(1);
          if (bit_cnt == CNT_W'(1)) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          bcd   <= bcd_work;
          ovf   <= ovf_pend;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/score_display_mux.sv
// Multiplexed 7-segment score display: BCD conversion plus one-digit-per-slot scan.
// Optional SCORE_LEADING_BLANK_EN blanks zero digits above the most significant non-zero one.
module score_display_mux
  import score_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCORE_W     = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SCORE_W-1:0]    score,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  busy,
  output logic                  ovf
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] disp;
  logic [CNT_W-1:0]        ref_cnt;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              cur_digit;
  logic                    blank;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCORE_W    (SCORE_W)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .score (score),
    .bcd   (disp),
    .busy  (busy),
    .ovf   (ovf)
  );

  assign cur_digit = disp[idx*4 +: 4];

`ifdef SCORE_LEADING_BLANK_EN
  logic [IDX_W-1:0] msd;

  // Position of the highest non-zero digit; digit 0 is always lit.
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (disp[4*i +: 4] != 4'd0) begin
        msd = IDX_W'(i);
      end else begin
        msd = msd;
      end
    end
  end

  assign blank = (idx > msd);
`else
  assign blank = 1'b0;
`endif

  assign seg_next = blank ? SEG_BLANK : seg_decode(cur_digit);
  assign an_next  = ~(NUM_DIGITS'(1) << idx);

  // Slot timer and digit index; outputs are registered from the index, so they lag it by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      idx     <= '0;
      seg     <= SEG_0;
      an_n    <= ~NUM_DIGITS'(1);
    end else begin
      if (ref_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        if (idx == IDX_W'(NUM_DIGITS - 1)) begin
          idx <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else begin
        ref_cnt <= ref_cnt + CNT_W'(1);
      end
      seg  <= seg_next;
      an_n <= an_next;
    end
  end

endmodule

// File: tb/tb_score_display_mux.sv
// Randomized self-checking bench for score_display_mux, checked against an
// arithmetic model of the displayed number and the scan position.
module tb_score_display_mux;

  localparam int ND = 4;
  localparam int SW = 14;
  localparam int RD = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                          7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
                                          7'b1111111, 7'b1111011};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] score = '0;
  logic [6:0]    seg;
  logic [ND-1:0] an_n;
  logic          busy;
  logic          ovf;

  int checks = 0;
  int errors = 0;
  int cyc;
  int last_m = 0;
  int disp_m = 0;
  bit ovf_m  = 1'b0;

  score_display_mux #(.NUM_DIGITS(ND), .SCORE_W(SW), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .score(score), .seg(seg), .an_n(an_n), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic int pow10i(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int exp_idx(input int c);
    return (c == 0) ? 0 : ((c - 1) / RD) % ND;
  endfunction

  function automatic logic [6:0] exp_seg(input int c, input int val);
    int v = val;
    int i = exp_idx(c);
    int d;
    if (v > pow10i(ND) - 1) v = pow10i(ND) - 1;
    d = (v / pow10i(i)) % 10;
`ifdef SCORE_LEADING_BLANK_EN
    if (i > 0 && v < pow10i(i)) return 7'b0000000;
`endif
    return SEG_TAB[d];
  endfunction

  function automatic logic [ND-1:0] exp_an(input int c);
    logic [ND-1:0] one = 1;
    return ~(one << exp_idx(c));
  endfunction

  // Drive a new score and count how many sampled cycles busy stays high (bounded).
  task automatic apply_score(input int v, output int nbusy);
    bit seen = 1'b0;
    @(negedge clk);
    score = SW'(v);
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) begin
        nbusy++;
        seen = 1'b1;
      end else if (seen || k >= 3) begin
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    score = '0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (seg !== 7'b1111110) begin errors++; $display("FAIL reset_seg got=%b exp=1111110", seg); end
    if (an_n !== 4'b1110) begin errors++; $display("FAIL reset_an got=%b exp=1110", an_n); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst_n = 1'b1;
    last_m = 0; disp_m = 0; ovf_m = 1'b0;
  endtask

  task automatic test_convert(input int v);
    int nb;
    int exp_nb = (v != last_m) ? 15 : 0;
    apply_score(v, nb);
    if (v != last_m) begin
      disp_m = v;
      ovf_m  = (v > pow10i(ND) - 1);
      last_m = v;
    end
    checks += 2;
    if (nb !== exp_nb) begin errors++; $display("FAIL busy_len score=%0d got=%0d exp=%0d", v, nb, exp_nb); end
    if (ovf !== ovf_m) begin errors++; $display("FAIL ovf score=%0d got=%b exp=%b", v, ovf, ovf_m); end
  endtask

  task automatic test_scan(input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      checks += 2;
      if (seg !== exp_seg(cyc, disp_m)) begin
        errors++; $display("FAIL scan_seg val=%0d cyc=%0d got=%b exp=%b", disp_m, cyc, seg, exp_seg(cyc, disp_m));
      end
      if (an_n !== exp_an(cyc)) begin
        errors++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, an_n, exp_an(cyc));
      end
    end
  endtask

  // Score changes during conversion are ignored, then picked up once back in idle.
  task automatic test_mid_change();
    int nb = 0;
    @(negedge clk);
    score = SW'(5);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 4) score = SW'(9);
      if (busy) nb++;
      if (k == 16) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_gap_busy got=%b exp=0", busy); end
      end
      if (k >= 17 && k <= 31) begin
        checks++;
        if (seg !== exp_seg(cyc, 5)) begin
          errors++; $display("FAIL mid_first_seg cyc=%0d got=%b exp=%b", cyc, seg, exp_seg(cyc, 5));
        end
      end
    end
    checks++;
    if (nb !== 30) begin errors++; $display("FAIL mid_busy_total got=%0d exp=30", nb); end
    last_m = 9; disp_m = 9; ovf_m = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int v = int'($urandom_range(0, (1 << SW) - 1));
      int nb;
      int exp_nb = (v != last_m) ? 15 : 0;
      apply_score(v, nb);
      if (v != last_m) begin
        disp_m = v; ovf_m = (v > pow10i(ND) - 1); last_m = v;
      end
      checks += 2;
      if (nb !== exp_nb) begin errors++; $display("FAIL rand_busy score=%0d got=%0d exp=%0d", v, nb, exp_nb); end
      if (ovf !== ovf_m) begin errors++; $display("FAIL rand_ovf score=%0d got=%b exp=%b", v, ovf, ovf_m); end
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        checks++;
        if (seg !== exp_seg(cyc, disp_m)) begin
          errors++; $display("FAIL rand_seg val=%0d cyc=%0d got=%b exp=%b", disp_m, cyc, seg, exp_seg(cyc, disp_m));
        end
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    @(negedge clk);
    score = SW'(4321);
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (seg !== 7'b1111110) begin errors++; $display("FAIL midrst_seg got=%b exp=1111110", seg); end
    if (an_n !== 4'b1110) begin errors++; $display("FAIL midrst_an got=%b exp=1110", an_n); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got=%b exp=0", ovf); end
    score = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_m = 0; disp_m = 0; ovf_m = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL postrst_busy got=%b exp=0", busy); end
    end
  endtask

  initial begin
    test_reset();
    test_scan(8);
    test_convert(0);
    test_convert(1234);
    test_scan(20);
    test_convert(9999);
    test_convert(10000);
    test_scan(16);
    test_convert(12000);
    test_convert(7);
    test_scan(16);
    test_mid_change();
    test_scan(16);
    test_random();
    test_convert(12000);
    test_reset_mid_conv();
    test_scan(16);
    test_convert(42);
    test_scan(16);
    test_convert(42);
    test_scan(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
